// File: rtl/counter_gate_ctrl.sv
// Gated measurement sequencer for a prescaled event counter: clears the counter,
// opens a gate window of a programmed length, then captures count and wrap status.
module counter_gate_ctrl #(
   parameter int COUNT_W = 8,
   parameter int GATE_W  = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [GATE_W-1:0]  gate_len_i,
   input  logic               event_i,
   output logic               counter_reset_o,
   output logic               counter_enable_o,
   input  logic [COUNT_W-1:0] counter_count_i,
   output logic [COUNT_W-1:0] result_o,
   output logic               overflow_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic               busy_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      HOLD   = 3'd4
   } state_t;

   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

   state_t             r_state;
   state_t             w_nextState;
   logic [GATE_W-1:0]  r_len;
   logic [GATE_W-1:0]  r_gateCnt;
   logic [COUNT_W-1:0] r_prev;
   logic [COUNT_W-1:0] r_result;
   logic               r_sticky;
   logic               r_overflow;
   logic               r_counterReset;
   logic               w_lastRun;
   logic               w_wrap;

   // The gate counter starts at zero on the first RUN cycle, so RUN lasts exactly r_len cycles.
   assign w_lastRun = (r_gateCnt == (r_len - GATE_ONE));
   assign w_wrap    = (counter_count_i < r_prev);

   always_comb begin
      w_nextState      = r_state;
      counter_enable_o = 1'b0;
      busy_o           = 1'b1;
      result_valid_o   = 1'b0;
      case (r_state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               w_nextState = CLEAR;
            end
         end
         CLEAR: begin
            if (abort_i) begin
               w_nextState = IDLE;
            end else if (r_len != '0) begin
               w_nextState = RUN;
            end else begin
               w_nextState = SETTLE;
            end
         end
         RUN: begin
            counter_enable_o = event_i & ~abort_i;
            if (abort_i) begin
               w_nextState = IDLE;
            end else if (w_lastRun) begin
               w_nextState = SETTLE;
            end
         end
         SETTLE: begin
            w_nextState = abort_i ? IDLE : HOLD;
         end
         HOLD: begin
            result_valid_o = 1'b1;
            if (result_ready_i) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state        <= IDLE;
         r_len          <= '0;
         r_gateCnt      <= '0;
         r_prev         <= '0;
         r_result       <= '0;
         r_sticky       <= 1'b0;
         r_overflow     <= 1'b0;
         r_counterReset <= 1'b0;
      end else begin
         r_state        <= w_nextState;
         r_counterReset <= (w_nextState == CLEAR);
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_len <= gate_len_i;
               end
            end
            CLEAR: begin
               r_gateCnt <= '0;
               r_prev    <= '0;
               r_sticky  <= 1'b0;
            end
            RUN: begin
               r_gateCnt <= r_gateCnt + GATE_ONE;
               r_prev    <= counter_count_i;
               if (w_wrap) begin
                  r_sticky <= 1'b1;
               end
            end
            SETTLE: begin
               r_prev <= counter_count_i;
               if (w_wrap) begin
                  r_sticky <= 1'b1;
               end
               // A wrap seen on the settle cycle itself must still reach the captured flag.
               if (!abort_i) begin
                  r_result   <= counter_count_i;
                  r_overflow <= r_sticky | w_wrap;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign counter_reset_o = r_counterReset;
   assign result_o        = r_result;
   assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_counter_gate_ctrl.sv
// Testbench for counter_gate_ctrl: drives measurements against a prescaled counter stub
// and predicts each result from the number of enabled clocks in the window.
module tb_counter_gate_ctrl;

   localparam int COUNT_W = 8;
   localparam int GATE_W  = 16;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [GATE_W-1:0]  gateLen;
   logic               ev;
   logic               ready;
   logic               counterReset;
   logic               counterEnable;
   logic [COUNT_W-1:0] countVal = '0;
   logic [2:0]         prescale = '0;
   logic [COUNT_W-1:0] result;
   logic               overflow;
   logic               resultValid;
   logic               busy;

   int total = 0;
   int bad   = 0;
   logic [COUNT_W-1:0] lastRes;
   logic               lastOvf;

   always #5 clock = ~clock;

   counter_gate_ctrl #(.COUNT_W(COUNT_W), .GATE_W(GATE_W)) dut (
      .clock_i          (clock),
      .reset_i          (reset),
      .start_i          (start),
      .abort_i          (abort),
      .gate_len_i       (gateLen),
      .event_i          (ev),
      .counter_reset_o  (counterReset),
      .counter_enable_o (counterEnable),
      .counter_count_i  (countVal),
      .result_o         (result),
      .overflow_o       (overflow),
      .result_valid_o   (resultValid),
      .result_ready_i   (ready),
      .busy_o           (busy)
   );

   // Stand-in for the external counter: count advances once per eight enabled clocks.
   always @(posedge clock) begin
      if (counterReset) begin
         prescale <= '0;
         countVal <= '0;
      end else if (counterEnable) begin
         prescale <= prescale + 3'd1;
         if (prescale == 3'd7) begin
            countVal <= countVal + 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: event always high, 1: alternating starting high, otherwise random
   task automatic applyStimulus(input int len, input int mode);
      int   nEn;
      logic e;
      nEn     = 0;
      start   = 1'b1;
      gateLen = GATE_W'(len);
      tick();
      start   = 1'b0;
      checkOutput("clear_counter_reset", 32'(counterReset), 32'd1);
      checkOutput("clear_busy", 32'(busy), 32'd1);
      checkOutput("clear_enable", 32'(counterEnable), 32'd0);
      tick();
      for (int k = 0; k < len; k++) begin
         case (mode)
            0:       e = 1'b1;
            1:       e = ((k % 2) == 0);
            default: e = 1'($urandom_range(0, 1));
         endcase
         ev = e;
         #1;
         checkOutput("run_enable", 32'(counterEnable), 32'(e));
         if (k == 0) begin
            checkOutput("run_counter_reset", 32'(counterReset), 32'd0);
            checkOutput("run_valid", 32'(resultValid), 32'd0);
         end
         if (e) nEn++;
         tick();
      end
      ev = 1'b1;
      #1;
      checkOutput("settle_enable", 32'(counterEnable), 32'd0);
      checkOutput("settle_valid", 32'(resultValid), 32'd0);
      tick();
      ev = 1'b0;
      lastRes = COUNT_W'((nEn / 8) % 256);
      lastOvf = (nEn >= 2048);
      checkOutput("hold_valid", 32'(resultValid), 32'd1);
      checkOutput("hold_result", 32'(result), 32'(lastRes));
      checkOutput("hold_overflow", 32'(overflow), 32'(lastOvf));
   endtask

   // Holds off the consumer for a while with start pulsed, then completes the handshake.
   task automatic finishHold(input int delay);
      ready = 1'b0;
      for (int d = 0; d < delay; d++) begin
         start = 1'b1;
         tick();
         checkOutput("bp_valid", 32'(resultValid), 32'd1);
         checkOutput("bp_result", 32'(result), 32'(lastRes));
         checkOutput("bp_overflow", 32'(overflow), 32'(lastOvf));
         checkOutput("bp_busy", 32'(busy), 32'd1);
      end
      start = 1'b1;
      ready = 1'b1;
      tick();
      start = 1'b0;
      ready = 1'b0;
      checkOutput("done_valid", 32'(resultValid), 32'd0);
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_result", 32'(result), 32'(lastRes));
      tick();
      checkOutput("idle_after_handshake_busy", 32'(busy), 32'd0);
      checkOutput("idle_after_handshake_clear", 32'(counterReset), 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      ev      = 1'b0;
      ready   = 1'b0;
      gateLen = '0;
      lastRes = '0;
      lastOvf = 1'b0;
      tick();
      tick();
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      checkOutput("reset_valid", 32'(resultValid), 32'd0);
      checkOutput("reset_counter_reset", 32'(counterReset), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      applyStimulus(16, 0);
      finishHold(0);
      applyStimulus(20, 1);
      finishHold(0);
      applyStimulus(2047, 0);
      finishHold(1);
      applyStimulus(2048, 0);
      finishHold(0);
      applyStimulus(0, 0);
      finishHold(0);
      applyStimulus(100, 0);
      finishHold(5);

      // Abort on the fifth RUN cycle of a 64-clock window.
      start   = 1'b1;
      gateLen = GATE_W'(64);
      tick();
      start = 1'b0;
      tick();
      ev = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      abort = 1'b1;
      #1;
      checkOutput("abort_cycle_enable", 32'(counterEnable), 32'd0);
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_valid", 32'(resultValid), 32'd0);
      checkOutput("abort_enable", 32'(counterEnable), 32'd0);
      checkOutput("abort_result", 32'(result), 32'(lastRes));
      ev = 1'b0;
      tick();
      checkOutput("abort_still_idle", 32'(resultValid), 32'd0);

      applyStimulus(40, 2);
      finishHold(2);
      applyStimulus(2100, 0);
      finishHold(0);
      for (int r = 0; r < 6; r++) begin
         applyStimulus(int'($urandom_range(0, 400)), 2);
         finishHold(int'($urandom_range(0, 3)));
      end
      applyStimulus(100, 0);
      finishHold(0);

      // Reset in the middle of RUN must drop everything back to reset values.
      start   = 1'b1;
      gateLen = GATE_W'(30);
      tick();
      start = 1'b0;
      ev    = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midrun_reset_result", 32'(result), 32'd0);
      checkOutput("midrun_reset_overflow", 32'(overflow), 32'd0);
      checkOutput("midrun_reset_valid", 32'(resultValid), 32'd0);
      checkOutput("midrun_reset_counter_reset", 32'(counterReset), 32'd0);
      checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
      checkOutput("midrun_reset_enable", 32'(counterEnable), 32'd0);
      ev = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_gate_ctrl.md
Name: counter_gate_ctrl

Overview:
Measurement sequencer for the 8-bit prescaled event counter (count increments once per 8 enabled clocks). On a start request it clears the counter and opens a gate window of a programmed number of clocks. During the window it forwards qualified events to the counter's enable. It then captures the counter value, flags wrap-around, and holds the result on a valid/ready interface. Sits between the control logic that requests measurements and one counter instance.

Parameters:
COUNT_W, 8, width of the counter value returned by the counter and of result_o
GATE_W, 16, width of the gate-length input, in clock cycles

Ports:
clock_i  input  1  system clock; all logic on posedge
reset_i  input  1  synchronous active-high reset
start_i  input  1  measurement request; sampled only in IDLE
abort_i  input  1  cancel the measurement in progress
gate_len_i  input  GATE_W  gate window length in clocks; latched when start is accepted
event_i  input  1  event qualifier; counted only while the gate is open
counter_reset_o  output  1  drives the counter's reset_i
counter_enable_o  output  1  drives the counter's enable_i
counter_count_i  input  COUNT_W  counter's count_o
result_o  output  COUNT_W  captured count
overflow_o  output  1  counter wrapped at least once during the measurement
result_valid_o  output  1  result_o/overflow_o are valid
result_ready_i  input  1  consumer accepts the result
busy_o  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE; result_o=0, overflow_o=0, result_valid_o=0, counter_reset_o=0, busy_o=0; gate counter, latched length and prev-count register all cleared. Reset mid-measurement aborts it; no result is produced.
- States: IDLE, CLEAR, RUN, SETTLE, HOLD.
- IDLE: start_i=1 latches gate_len_i into len_q and moves to CLEAR.
- CLEAR (1 cycle): counter_reset_o=1 (registered output, high only in this state). Clear the gate counter, the overflow sticky and prev_q. Go to RUN if len_q!=0, else SETTLE.
- RUN (exactly len_q cycles): counter_enable_o = event_i, combinational. Outside RUN, counter_enable_o=0. After the len_q-th cycle, go to SETTLE.
- SETTLE (1 cycle): no enable. counter_count_i now reflects the last RUN edge. At the end of SETTLE, register result_o <= counter_count_i and overflow_o <= sticky (including a wrap detected in SETTLE itself). Go to HOLD.
- Overflow detection: in RUN and SETTLE, prev_q <= counter_count_i each cycle; if counter_count_i < prev_q, set sticky.
- HOLD: result_valid_o=1. result_o and overflow_o stay stable until handshake. When result_valid_o & result_ready_i, go to IDLE with valid=0 next cycle; result_o/overflow_o keep their last values.
- Latency: with start sampled at edge 0, CLEAR is cycle 1, RUN is cycles 2..len+1, SETTLE is cycle len+2, and result_valid_o rises in cycle len+3.
- start_i outside IDLE is ignored; it is not queued. start_i in the same cycle the HOLD handshake completes is ignored; a new start is accepted only once state=IDLE.
- abort_i in CLEAR/RUN/SETTLE: go to IDLE next cycle, enable forced 0, no result, outputs unchanged. abort_i in HOLD is ignored; the pending result is still delivered. abort_i has priority over state advance.
- len_q=2^GATE_W-1 is the maximum window; no wrap of the gate counter is permitted.
- The counter is not reset between measurements except via CLEAR. The residual prescale phase is discarded by CLEAR.

Test Plan:
- Reset, then start with gate_len=16, event_i=1 constant -> 16 enable pulses; result_valid in cycle 19 after start; result_o=2, overflow_o=0; ready=1 returns to IDLE.
- gate_len=20, event_i toggling 1/0 starting at 1 -> 10 enables; result_o=1, overflow_o=0.
- gate_len=2047, event_i=1 -> result_o=255, overflow_o=0. gate_len=2048 -> result_o=0, overflow_o=1.
- gate_len=0 -> no enables; result_valid in cycle 3; result_o=0, overflow_o=0.
- Backpressure: result_ready_i low for 5 cycles in HOLD with start_i=1 pulsed -> result stable, start ignored, busy_o=1; ready high -> IDLE, next start accepted.
- abort_i in RUN cycle 5 of gate_len=64 -> IDLE next cycle, counter_enable_o=0, no result_valid. reset_i asserted in RUN -> all outputs return to reset values.
